// File: rtl/bcd_convert_seq.sv
// Iterative double-dabble binary-to-BCD converter with valid/ready handshake on both sides.
// Optional macro SIGNED_INPUT_EN: two's-complement input, magnitude converted, sign on out_neg.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | in_ready=1, waiting for an operand
// ST_SHIFT | busy=1, one add-3/shift step per cycle for WIDTH cycles
// ST_DONE  | out_valid=1, result held until out_ready

module bcd_convert_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
`ifdef SIGNED_INPUT_EN
  output logic                  out_neg,
`endif
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic bit digits_ok();
    longint unsigned p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p > ((64'd1 << WIDTH) - 64'd1);
  endfunction

  localparam bit DIGITS_OK = digits_ok();

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     out_bcd_q, out_bcd_d;
  logic              neg_pend_q, neg_pend_d;
  logic              out_neg_q, out_neg_d;

  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_shift;
  logic [WIDTH-1:0]  operand;
  logic              operand_neg;

  // Each digit >= 5 gets +3 so the following left shift carries correctly into the next digit.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
`ifdef SIGNED_INPUT_EN
    operand_neg = in_data[WIDTH-1];
    operand     = operand_neg ? (~in_data + WIDTH'(1)) : in_data;
`else
    operand_neg = 1'b0;
    operand     = in_data;
`endif
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    out_bcd_d  = out_bcd_q;
    neg_pend_d = neg_pend_q;
    out_neg_d  = out_neg_q;
    bcd_adj    = add3(bcd_q);
    bcd_shift  = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          bin_d      = operand;
          bcd_d      = '0;
          cnt_d      = CW'(WIDTH);
          neg_pend_d = operand_neg;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_bcd_d = bcd_shift;
          out_neg_d = neg_pend_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      assert (DIGITS_OK);
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      out_bcd_q  <= '0;
      neg_pend_q <= 1'b0;
      out_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      out_bcd_q  <= out_bcd_d;
      neg_pend_q <= neg_pend_d;
      out_neg_q  <= out_neg_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT);
  assign out_valid = (state_q == ST_DONE);
  assign out_bcd   = out_bcd_q;
`ifdef SIGNED_INPUT_EN
  assign out_neg   = out_neg_q;
`else
  logic unused_neg;
  assign unused_neg = out_neg_q ^ neg_pend_q ^ operand_neg;
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Randomized bench for bcd_convert_seq against an arithmetic decimal-digit reference model.
// Build with SIGNED_INPUT_EN defined to exercise the signed variant.

module tb_bcd_convert_seq;

  localparam int W = 16;
  localparam int D = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [4*D-1:0] out_bcd;
`ifdef SIGNED_INPUT_EN
  logic          out_neg;
`endif

  bcd_convert_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
`ifdef SIGNED_INPUT_EN
    .out_neg   (out_neg),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int             n_chk = 0;
  int             n_fail = 0;
  logic [4*D-1:0] prev_bcd = '0;
  logic           prev_neg = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] ref_bcd(input logic [W-1:0] d, output logic neg);
    int unsigned mag;
    int unsigned p;
    logic [4*D-1:0] r;
`ifdef SIGNED_INPUT_EN
    neg = d[W-1];
    mag = neg ? (32'd65536 - 32'(d)) : 32'(d);
`else
    neg = 1'b0;
    mag = 32'(d);
`endif
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((mag / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check_sign(input string tag, input logic exp);
`ifdef SIGNED_INPUT_EN
    chk(tag, 32'(out_neg), 32'(exp));
`else
    if (exp) chk(tag, 32'd0, 32'd1);
`endif
  endtask

  // Called at a negedge; completes one operand through to the result handshake.
  task automatic convert(input logic [W-1:0] d, input int stall, input bit hold);
    logic [4*D-1:0] exp;
    logic           eneg;
    int             n;
    int             busy_n;
    exp = ref_bcd(d, eneg);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'(n), 32'd0);
      return;
    end
    @(negedge clk);
    busy_n = 0;
    n = 1;
    while (!out_valid && n < 40) begin
      chk("busy", 32'(busy), 32'd1);
      chk("in_ready_shift", 32'(in_ready), 32'd0);
      chk("bcd_hold", 32'(out_bcd), 32'(prev_bcd));
      check_sign("neg_hold", prev_neg);
      busy_n++;
      out_ready = 1'($urandom);
      if (!hold) begin
        in_valid = 1'($urandom);
        in_data  = 16'($urandom);
      end
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(W + 1));
    chk("busy_cycles", 32'(busy_n), 32'(W));
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      if (!hold) begin
        in_valid = 1'($urandom);
        in_data  = 16'($urandom);
      end
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_bcd", 32'(out_bcd), 32'(exp));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk("done_valid", 32'(out_valid), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("out_bcd", 32'(out_bcd), 32'(exp));
    check_sign("out_neg", eneg);
    out_ready = 1'b1;
    in_valid  = hold;
    @(negedge clk);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_bcd_hold", 32'(out_bcd), 32'(exp));
    out_ready = 1'b0;
    prev_bcd  = exp;
    prev_neg  = eneg;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(out_bcd), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    check_sign("rst_neg", 1'b0);

    convert(16'd0, 0, 1'b0);
    convert(16'd65535, 0, 1'b0);
    convert(16'd1234, 10, 1'b0);
    convert(16'd9, 0, 1'b1);
    convert(16'd10, 2, 1'b1);
    in_valid = 1'b0;

    // Reset in the middle of a conversion must discard it.
    in_valid = 1'b1;
    in_data  = 16'd4095;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bcd", 32'(out_bcd), 32'd0);
    prev_bcd = '0;
    prev_neg = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(out_valid), 32'd0);
    end
    convert(16'd42, 1, 1'b0);

    convert(16'hFFFF, 0, 1'b0);
    convert(16'h8000, 1, 1'b0);
    convert(16'h7FFF, 0, 1'b0);
    convert(16'd99, 0, 1'b0);
    convert(16'd100, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      convert(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
